// File: rtl/mvb_pkg.sv
// Shared definitions for the MVB frame parser: F_code values, FSM states and
// the F_code to slave-reply-length decode.
package mvb_pkg;

    localparam logic [3:0] FC_PD16  = 4'd0;
    localparam logic [3:0] FC_PD32  = 4'd1;
    localparam logic [3:0] FC_PD64  = 4'd2;
    localparam logic [3:0] FC_PD128 = 4'd3;
    localparam logic [3:0] FC_PD256 = 4'd4;
    localparam logic [3:0] FC_MTR   = 4'd8;
    localparam logic [3:0] FC_GEV   = 4'd9;
    localparam logic [3:0] FC_MSG   = 4'd12;
    localparam logic [3:0] FC_GRP   = 4'd13;
    localparam logic [3:0] FC_SEV   = 4'd14;
    localparam logic [3:0] FC_DST   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_SLAVE = 3'd1,
        ST_RX_SLAVE   = 3'd2,
        ST_DISCARD    = 3'd3,
        ST_DRAIN      = 3'd4
    } state_e;

    // Returns {reserved, reply length in words}.
    function automatic logic [5:0] fcode_len(input logic [3:0] fcode);
        logic [5:0] r;
        r = {1'b1, 5'd0};
        case (fcode)
            FC_PD16:  r = {1'b0, 5'd1};
            FC_PD32:  r = {1'b0, 5'd2};
            FC_PD64:  r = {1'b0, 5'd4};
            FC_PD128: r = {1'b0, 5'd8};
            FC_PD256: r = {1'b0, 5'd16};
            FC_MTR, FC_GEV, FC_GRP, FC_SEV, FC_DST: r = {1'b0, 5'd1};
            FC_MSG:   r = {1'b0, 5'd16};
            default:  r = {1'b1, 5'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mvb_frame_parser_if.sv
// Word stream from the decoder and the burst towards port memory.
// Handshakes: in_* words transfer on a cycle with in_valid & in_ready; out_* words transfer on a cycle with out_valid & out_ready, and the out_* payload holds while out_valid & !out_ready.
interface mvb_frame_parser_if #(
    parameter int unsigned PORT_AW = 12
);
    logic               in_valid;
    logic [15:0]        in_data;
    logic               in_master;
    logic               in_last;
    logic               in_err;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic [PORT_AW+3:0] out_addr;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_master, in_last, in_err, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  in_valid, in_data, in_master, in_last, in_err, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/mvb_reply_timer.sv
// Down-counter for reply supervision: load, count down while running, flag
// expiry when it sits at zero while running.
module mvb_reply_timer #(
    parameter int unsigned LOAD_VAL = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int unsigned TW = $clog2(LOAD_VAL + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TW'(LOAD_VAL);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/mvb_frame_parser.sv
// MVB frame parser: decodes master frames, stages and checks the slave reply,
// then bursts it to port memory. Define MVB_PARSER_STATS_EN for statistics.
module mvb_frame_parser
    import mvb_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 24000000,
    parameter int unsigned REPLY_TIMEOUT = 1024,
    parameter int unsigned PORT_AW       = 12
) (
    input  logic              clk,
    input  logic              rst,
    mvb_frame_parser_if.slave bus,
    output logic              mf_valid,
    output logic [3:0]        mf_fcode,
    output logic [11:0]       mf_addr,
    output logic              slave_done,
    output logic              slave_err,
    output logic              timeout,
`ifdef MVB_PARSER_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_err,
    output logic [15:0]       stat_timeout,
    output logic [15:0]       stat_drop,
`endif
    output state_e            dbg_state
);

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  exp_len_q, exp_len_d;
    logic [3:0]  fcode_q, fcode_d;
    logic [11:0] addr_q, addr_d;
    logic        mf_valid_q, mf_valid_d;
    logic        slave_done_q, slave_done_d;
    logic        slave_err_q, slave_err_d;
    logic        timeout_q, timeout_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] stage_q [16];

    logic        stage_we;
    logic        tmr_load, tmr_run, tmr_expired;
    logic        word, master_word, slave_word;
    logic        take_master, take_slave;
    logic [5:0]  len_info;

    assign word        = bus.in_valid && in_ready_q;
    assign master_word = word && bus.in_master;
    assign slave_word  = word && !bus.in_master;
    assign len_info    = fcode_len(bus.in_data[15:12]);
    assign tmr_run     = (state_q == ST_WAIT_SLAVE);

    mvb_reply_timer #(
        .LOAD_VAL(REPLY_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst),
        .load   (tmr_load),
        .run    (tmr_run),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        exp_len_d    = exp_len_q;
        fcode_d      = fcode_q;
        addr_d       = addr_q;
        mf_valid_d   = 1'b0;
        slave_done_d = 1'b0;
        slave_err_d  = 1'b0;
        timeout_d    = 1'b0;
        tmr_load     = 1'b0;
        stage_we     = 1'b0;
        take_master  = 1'b0;
        take_slave   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_master = master_word;
            end
            ST_WAIT_SLAVE: begin
                if (master_word) begin
                    take_master = 1'b1;
                end else if (slave_word) begin
                    take_slave = 1'b1;
                end else if (tmr_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RX_SLAVE: begin
                if (master_word) begin
                    slave_err_d = 1'b1;
                    take_master = 1'b1;
                end else if (slave_word) begin
                    take_slave = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (word && bus.in_last) begin
                    slave_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (count_q == exp_len_q - 5'd1) begin
                        slave_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new master word always restarts the transaction, whatever came before.
        if (take_master) begin
            if (!bus.in_last) begin
                state_d = ST_DISCARD;
            end else if (bus.in_err || len_info[5]) begin
                slave_err_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                fcode_d    = bus.in_data[15:12];
                addr_d     = bus.in_data[11:0];
                exp_len_d  = len_info[4:0];
                mf_valid_d = 1'b1;
                tmr_load   = 1'b1;
                count_d    = '0;
                state_d    = ST_WAIT_SLAVE;
            end
        end

        if (take_slave) begin
            if (count_q == exp_len_q) begin
                if (bus.in_last) begin
                    slave_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end else begin
                stage_we = 1'b1;
                count_d  = count_q + 5'd1;
                state_d  = ST_RX_SLAVE;
                if (bus.in_last) begin
                    if (bus.in_err || (count_q + 5'd1 != exp_len_q)) begin
                        slave_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        count_d = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
        end

        if (state_d == ST_IDLE) begin
            count_d = '0;
        end

        in_ready_d  = (state_d != ST_DRAIN);
        out_valid_d = (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            exp_len_q    <= '0;
            fcode_q      <= '0;
            addr_q       <= '0;
            mf_valid_q   <= 1'b0;
            slave_done_q <= 1'b0;
            slave_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            exp_len_q    <= exp_len_d;
            fcode_q      <= fcode_d;
            addr_q       <= addr_d;
            mf_valid_q   <= mf_valid_d;
            slave_done_q <= slave_done_d;
            slave_err_q  <= slave_err_d;
            timeout_q    <= timeout_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Staging RAM carries no reset; only the index is cleared.
    always_ff @(posedge clk) begin
        if (stage_we) begin
            stage_q[count_q[3:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? stage_q[count_q[3:0]] : 16'h0000;
    assign bus.out_addr  = {addr_q[PORT_AW-1:0], count_q[3:0]};
    assign bus.out_last  = out_valid_q && (count_q == exp_len_q - 5'd1);
    assign mf_valid      = mf_valid_q;
    assign mf_fcode      = fcode_q;
    assign mf_addr       = addr_q;
    assign slave_done    = slave_done_q;
    assign slave_err     = slave_err_q;
    assign timeout       = timeout_q;
    assign dbg_state     = state_q;

`ifdef MVB_PARSER_STATS_EN
    // Counter order: 0 ok, 1 err, 2 timeout, 3 drop; all saturate at 16'hFFFF.
    logic [15:0] stat_q [4];
    logic [15:0] stat_d [4];
    logic [3:0]  stat_ev;
    logic        drop_ev;

    assign drop_ev = ((state_q == ST_DRAIN) && bus.in_valid) ||
                     ((state_q == ST_IDLE) && slave_word);
    assign stat_ev = {drop_ev, timeout_d, slave_err_d, slave_done_d};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stat_d[i] = stat_q[i];
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (stat_ev[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) stat_q[i] <= stat_d[i];
        end
    end

    assign stat_ok      = stat_q[0];
    assign stat_err     = stat_q[1];
    assign stat_timeout = stat_q[2];
    assign stat_drop    = stat_q[3];
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_mvb_frame_parser.sv
// Directed bench for mvb_frame_parser: a scoreboard queue holds expected burst
// words, pulse monitors count events, immediate assertions do the checking.
module tb_mvb_frame_parser;
  import mvb_pkg::*;

  localparam int unsigned RT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mvb_frame_parser_if #(.PORT_AW(12)) bus ();

  logic        mf_valid;
  logic [3:0]  mf_fcode;
  logic [11:0] mf_addr;
  logic        slave_done;
  logic        slave_err;
  logic        timeout;
  state_e      dbg_state;
`ifdef MVB_PARSER_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ok, stat_err, stat_timeout, stat_drop;
`endif

  mvb_frame_parser #(
    .REPLY_TIMEOUT(RT),
    .PORT_AW(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mf_valid  (mf_valid),
    .mf_fcode  (mf_fcode),
    .mf_addr   (mf_addr),
    .slave_done(slave_done),
    .slave_err (slave_err),
    .timeout   (timeout),
`ifdef MVB_PARSER_STATS_EN
    .stat_clr    (stat_clr),
    .stat_ok     (stat_ok),
    .stat_err    (stat_err),
    .stat_timeout(stat_timeout),
    .stat_drop   (stat_drop),
`endif
    .dbg_state (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  int cyc = 0;
  int cnt_mf = 0, cnt_done = 0, cnt_err = 0, cnt_to = 0, cnt_outv = 0;
  int mf_cyc = 0, to_cyc = 0;
  int b_mf, b_done, b_err, b_to, b_outv, k;
  logic [15:0] d0, d1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: event counters and scoreboard pop, sampled on the falling edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (mf_valid) begin cnt_mf++; mf_cyc = cyc; end
    if (slave_done) cnt_done++;
    if (slave_err) cnt_err++;
    if (timeout) begin cnt_to++; to_cyc = cyc; end
    if (bus.out_valid) cnt_outv++;
    if (bus.out_valid && bus.out_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
      check("out_word", {7'd0, bus.out_last, bus.out_addr, bus.out_data}, {7'd0, e});
    end
  end

  task automatic send_word(input logic [15:0] d, input logic m, input logic l, input logic e);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_master = m;
    bus.in_last   = l;
    bus.in_err    = e;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_err    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_mf = cnt_mf; b_done = cnt_done; b_err = cnt_err; b_to = cnt_to; b_outv = cnt_outv;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_master = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_err    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MVB_PARSER_STATS_EN
    stat_clr = 1'b0;
`endif

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_pulses", {mf_valid, slave_done, slave_err, timeout, bus.out_last}, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: F_code 2, four-word reply, out_ready held high
    snap();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] idx;
      idx = 4'(i);
      exp_q.push_back({(i == 3), 12'h123, idx, 16'(16'h00A0 + i)});
    end
    send_word(16'h2123, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_word(16'(16'h00A0 + i), 1'b0, (i == 3), 1'b0);
    k = 0;
    do begin @(posedge clk); k++; end while (k < 40 && cnt_done == b_done);
    #1;
    check("s1_done", cnt_done - b_done, 1);
    check("s1_mf_valid", cnt_mf - b_mf, 1);
    check("s1_no_err", cnt_err - b_err, 0);
    check("s1_fields", {mf_fcode, mf_addr}, {4'd2, 12'h123});
    check("s1_queue_empty", exp_q.size(), 0);
    check("s1_state", dbg_state, ST_IDLE);

    // 2: F_code 0 with no reply -> timeout
    snap();
    send_word(16'h0456, 1'b1, 1'b1, 1'b0);
    k = 0;
    do begin @(posedge clk); k++; end while (k < RT + 50 && cnt_to == b_to);
    #1;
    check("s2_timeout", cnt_to - b_to, 1);
    check("s2_latency", to_cyc - mf_cyc, RT + 1);
    check("s2_state", dbg_state, ST_IDLE);
    check("s2_no_burst", cnt_outv - b_outv, 0);
    check("s2_fields", {mf_fcode, mf_addr}, {4'd0, 12'h456});

    // 3: F_code 3 expects 8 words, reply ends after 5
    snap();
    send_word(16'h3789, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_word(16'(16'hB000 + i), 1'b0, (i == 4), 1'b0);
    idle(4);
    check("s3_err", cnt_err - b_err, 1);
    check("s3_no_burst", cnt_outv - b_outv, 0);
    check("s3_no_done", cnt_done - b_done, 0);
    check("s3_state", dbg_state, ST_IDLE);

    // 4: F_code 1, two words but in_err on the last
    snap();
    send_word(16'h1ABC, 1'b1, 1'b1, 1'b0);
    send_word(16'hC001, 1'b0, 1'b0, 1'b0);
    send_word(16'hC002, 1'b0, 1'b1, 1'b1);
    idle(4);
    check("s4_mf_valid", cnt_mf - b_mf, 1);
    check("s4_err", cnt_err - b_err, 1);
    check("s4_no_burst", cnt_outv - b_outv, 0);

    // 5: reserved F_code
    snap();
    send_word(16'h5000, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("s5_err", cnt_err - b_err, 1);
    check("s5_no_mf", cnt_mf - b_mf, 0);
    check("s5_state", dbg_state, ST_IDLE);

    // 6: stalled drain with a word arriving during DRAIN
    snap();
    bus.out_ready = 1'b0;
    d0 = 16'($urandom_range(0, 65535));
    d1 = 16'($urandom_range(0, 65535));
    exp_q.push_back({1'b0, 16'hDEF0, d0});
    exp_q.push_back({1'b1, 16'hDEF1, d1});
    send_word(16'h1DEF, 1'b1, 1'b1, 1'b0);
    send_word(d0, 1'b0, 1'b0, 1'b0);
    send_word(d1, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (k < 10 && !bus.out_valid) begin @(posedge clk); k++; end
    #1;
    check("s6_out_valid", bus.out_valid, 1);
    check("s6_in_ready", bus.in_ready, 0);
    check("s6_state", dbg_state, ST_DRAIN);
    check("s6_word0", {bus.out_addr, bus.out_data}, {16'hDEF0, d0});
    send_word(16'h9999, 1'b0, 1'b1, 1'b0);
    check("s6_word0_held", {bus.out_last, bus.out_addr, bus.out_data}, {1'b0, 16'hDEF0, d0});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("s6_word1", {bus.out_last, bus.out_addr, bus.out_data}, {1'b1, 16'hDEF1, d1});
    idle(2);
    check("s6_word1_held", {bus.out_last, bus.out_data}, {1'b1, d1});
    check("s6_still_drain", dbg_state, ST_DRAIN);
    bus.out_ready = 1'b1;
    k = 0;
    do begin @(posedge clk); k++; end while (k < 20 && cnt_done == b_done);
    #1;
    check("s6_done", cnt_done - b_done, 1);
    check("s6_no_err", cnt_err - b_err, 0);
    check("s6_queue_empty", exp_q.size(), 0);
    check("s6_idle_ready", {dbg_state, bus.in_ready}, {ST_IDLE, 1'b1});

`ifdef MVB_PARSER_STATS_EN
    check("stat_drop", stat_drop, 1);
    check("stat_ok", stat_ok, 2);
    check("stat_err", stat_err, 3);
    check("stat_timeout", stat_timeout, 1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr", {stat_ok, stat_err, stat_timeout, stat_drop}, 0);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mvb_frame_parser.md
Name: mvb_frame_parser

Overview:
- Sits directly downstream of the MVB decoder. It consumes the 16-bit word stream that the decoder drains from its FIFO after each frame.
- Decodes master frames into F_code and address, and computes the expected slave reply length.
- Collects the slave reply into a 16-word staging buffer and checks its length, error status and reply timeout.
- On success, bursts the reply out to the port memory over a valid/ready handshake.

Parameters:
- CLK_HZ, 24000000, system clock frequency; documentation only.
- REPLY_TIMEOUT, 1024, clk cycles allowed between master accept and first slave word (42.7 us at 24 MHz).
- PORT_AW, 12, width of the address field forwarded on out_addr (max 12).

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe, in_data valid
- in_data  in  16  decoded frame word, MSB first on line
- in_master  in  1  1 = word belongs to master frame, 0 = slave frame
- in_last  in  1  last word of current frame
- in_err  in  1  OR of decoder error flags (length/signal/delimiter/quality/crc); valid with in_last
- in_ready  out  1  1 = words accepted; 0 only in DRAIN
- mf_valid  out  1  one-cycle pulse, master frame accepted
- mf_fcode  out  4  latched F_code
- mf_addr  out  12  latched address
- out_valid  out  1  staged slave word available
- out_ready  in  1  port memory accepts word
- out_data  out  16  slave word
- out_addr  out  PORT_AW+4  {mf_addr[PORT_AW-1:0], word_idx[3:0]}
- out_last  out  1  final word of burst
- slave_done  out  1  one-cycle pulse after last word handshakes
- slave_err  out  1  one-cycle pulse: reply rejected
- timeout  out  1  one-cycle pulse: no reply within REPLY_TIMEOUT

Behaviour:
- Reset: all outputs 0 except in_ready = 1; state IDLE; counters and staging buffer index 0. Staging buffer contents are not reset.
- exp_len (words), derived from F_code:
  - 0..4 -> 1 << F_code (1, 2, 4, 8, 16)
  - 8, 9, 13, 14, 15 -> 1
  - 12 -> 16
  - 5, 6, 7, 10, 11 -> reserved
- States: IDLE, WAIT_SLAVE, RX_SLAVE, DISCARD, DRAIN.
- IDLE:
  - Master word, in_last = 1, in_err = 0, F_code not reserved: latch fields; mf_valid next cycle; load timer = REPLY_TIMEOUT; -> WAIT_SLAVE.
  - Reserved F_code: slave_err pulse; stay IDLE.
  - Master word with in_last = 0: -> DISCARD.
  - in_err = 1 on a master frame: slave_err pulse; stay IDLE.
  - Slave words: ignored.
- WAIT_SLAVE:
  - Timer decrements each cycle. At 0: timeout pulse; -> IDLE.
  - Slave word: store at idx 0; idx = 1; -> RX_SLAVE. If in_last is also set, evaluate the end-of-frame check the same cycle.
  - New master word: handled exactly as in IDLE (restart; the previous master is abandoned).
- RX_SLAVE:
  - Each slave word is stored at idx; idx increments.
  - A word that would make count > exp_len: -> DISCARD, or straight to IDLE with slave_err if in_last.
  - On in_last: if in_err = 1 or count != exp_len -> slave_err, IDLE; else -> DRAIN with idx = 0.
  - A master word here: slave_err, then handled as in IDLE.
- DISCARD: drop words until in_last; then slave_err pulse; -> IDLE.
- DRAIN:
  - in_ready = 0; in_valid words are dropped.
  - out_valid = 1, out_data = stage[idx]; idx advances on out_valid & out_ready.
  - out_last = 1 when idx == exp_len-1. On that handshake: slave_done next cycle; -> IDLE.
- Output timing: all outputs registered; pulses are exactly 1 cycle.
- Timer width: $clog2(REPLY_TIMEOUT+1).
- Reset mid-operation: immediate return to IDLE; out_valid drops asynchronously.

Optional Feature:
- MVB_PARSER_STATS_EN defined:
  - Adds four 16-bit saturating counters, each with an output port: stat_ok, stat_err, stat_timeout, stat_drop.
  - stat_drop counts words lost in DRAIN or ignored slave words in IDLE.
  - stat_clr (in, 1): synchronous clear.
- Undefined: these ports and the logic are absent.

Decomposition:
- Package mvb_pkg:
  - F_code localparams (FC_PD16..FC_PD256, FC_MTR = 8, FC_GEV = 9, FC_MSG = 12, FC_GRP = 13, FC_SEV = 14, FC_DST = 15).
  - State enum.
  - Function fcode_len(fcode) -> {reserved, len[4:0]}.
- One sub-module: mvb_reply_timer (load/decrement/expire), reused by future master-side logic.

Test Plan:
- Master 0x2123 (F_code 2, addr 0x123), then 4 slave words A0..A3 with the last flagged, out_ready = 1 -> mf_valid; out_addr 0x1230..0x1233 with data A0..A3; out_last on the 4th; slave_done.
- Master F_code 0, no slave reply -> timeout pulse exactly REPLY_TIMEOUT+1 cycles after mf_valid; state IDLE.
- Master F_code 3 (8 words), slave sends 5 words with in_last -> slave_err; no out_valid.
- Master F_code 1, slave 2 words, in_err = 1 on the last -> slave_err; no burst.
- Master 0x5000 (reserved F_code) -> slave_err; no mf_valid.
- DRAIN with out_ready toggling 1-0-1 plus an in_valid pulse during DRAIN -> words held stable while stalled; in_ready = 0; stat_drop = 1 when MVB_PARSER_STATS_EN is defined.
